// File: rtl/core_pkg.sv
// Shared fetch/decode constants: datapath width, reset vector, PC stride and the ID bubble.
// Parameter-only package; no logic, no latency.
package core_pkg;
    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;
    localparam int              PC_STEP  = 4;
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; head is read straight from storage, count is registered.
// Push/pop take effect at the clock edge; push while full is dropped unless a pop frees the slot.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with up to DEPTH requests in flight plus a prefetch FIFO toward ID; a word
// granted in cycle T and returned in T+k is offered in T+k+1; issue stalls when in-flight + buffered reaches DEPTH.
module fetch_prefetch_unit #(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            cs_i_n,
    output logic [XLEN-1:0] i_addr,
    input  logic            i_gnt,
    input  logic            i_rvalid,
    input  logic [XLEN-1:0] i_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_4
);
    import core_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_cnt_q, discard_cnt_d;
    logic [CW-1:0]     inflight_next;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_used;
    logic [2*XLEN-1:0] head_dat;
    logic [XLEN-1:0]   redirect_tgt;
    logic              accept, rsp_vld, fifo_push, fifo_pop, fifo_flush;

    assign credit_used   = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign cs_i_n        = rst || (credit_used >= (CW + 1)'(DEPTH));
    assign i_addr        = fetch_pc_q;
    assign accept        = !cs_i_n && i_gnt;
    // A response with nothing in flight is a protocol violation and is ignored.
    assign rsp_vld       = i_rvalid && (outstanding_q != '0);
    assign inflight_next = outstanding_q + CW'(accept) - CW'(rsp_vld);
    assign redirect_tgt  = {redirect_pc[XLEN-1:2], 2'b00};
    assign instr_valid   = (fifo_count != '0);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = inflight_next;
        discard_cnt_d = discard_cnt_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_flush    = 1'b0;
        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            fetch_pc_d    = redirect_tgt;
            resp_pc_d     = redirect_tgt;
            discard_cnt_d = inflight_next;
            fifo_flush    = 1'b1;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            end
            if (rsp_vld) begin
                if (discard_cnt_q != '0) begin
                    discard_cnt_d = discard_cnt_q - CW'(1);
                end else begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + XLEN'(PC_STEP);
                end
            end
            fifo_pop = instr_valid && instr_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_cnt_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat ({i_data, resp_pc_q}),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign instr = instr_valid ? head_dat[2*XLEN-1:XLEN] : '0;
    assign pc    = instr_valid ? head_dat[XLEN-1:0] : '0;
    assign pc_4  = instr_valid ? head_dat[XLEN-1:0] + XLEN'(PC_STEP) : '0;

    rsp_without_request: assert property (@(posedge clk) disable iff (rst)
        !(i_rvalid && (outstanding_q == '0)));
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: in-order memory model plus a scoreboard of expected PCs.
module tb_fetch_prefetch_unit;
    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        cs_i_n;
    logic [31:0] i_addr;
    logic        i_gnt = 1'b0;
    logic        i_rvalid = 1'b0;
    logic [31:0] i_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr, pc, pc_4;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .cs_i_n(cs_i_n), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_data(i_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc(pc), .pc_4(pc_4)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          budget = -1;
    bit          mem_rand = 1'b0;
    logic [31:0] pend[$];
    logic [31:0] sb[$];
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] sb_head;
    logic        mem_go = 1'b0;
    logic [31:0] mem_addr = '0;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t vt[6];

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // In-order memory: a grant seen before edge T can be answered in cycle T+1 at the earliest.
    always begin
        @(negedge clk);
        if (rst) begin
            pend.delete();
            mem_go = 1'b0;
        end else begin
            if (!cs_i_n && i_gnt) pend.push_back(i_addr);
            mem_go = (pend.size() > 0) && (budget != 0) && (!mem_rand || ($urandom_range(0, 2) != 0));
            if (mem_go) begin
                mem_addr = pend.pop_front();
                if (budget > 0) budget--;
            end
        end
        @(posedge clk);
        #1;
        i_rvalid = mem_go;
        i_data   = mem_go ? word(mem_addr) : '0;
    end

    // Scoreboard: every accepted request on the current path must reach ID in order, nothing else may.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_fetch = RST_PC;
        end else begin
            if (!cs_i_n && i_gnt) acc_cnt++;
            if (!instr_valid) chk("idle_outputs_zero", instr | pc | pc_4, 32'h0);
            if (redirect_valid) begin
                sb.delete();
                exp_fetch = {redirect_pc[31:2], 2'b00};
            end else begin
                if (instr_valid && instr_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL stale_word: pc 0x%08h delivered with no request pending, want none", pc);
                    end else begin
                        sb_head = sb.pop_front();
                        pop_cnt++;
                        chk("pop_pc", pc, sb_head);
                        chk("pop_instr", instr, word(sb_head));
                        chk("pop_pc_4", pc_4, sb_head + 32'd4);
                    end
                end
                if (!cs_i_n && i_gnt) begin
                    chk("fetch_addr", i_addr, exp_fetch);
                    sb.push_back(exp_fetch);
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        i_gnt = 1'b0;
        instr_ready = 1'b0;
        budget = -1;
        mem_rand = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_cs_i_n", 32'(cs_i_n), 32'd1);
        chk("rst_i_addr", i_addr, RST_PC);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pc_4", pc_4, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int limit, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (instr_valid) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: instr_valid still 0 after %0d cycles, want 1", name, limit);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        vt[0] = '{32'h0000_0103, 32'h0000_0100};
        vt[1] = '{32'h0000_0007, 32'h0000_0004};
        vt[2] = '{32'h0000_0000, 32'h0000_0000};
        vt[3] = '{32'h0000_2001, 32'h0000_2000};
        vt[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC};
        vt[5] = '{32'h8000_0012, 32'h8000_0010};

        // Redirect target alignment, table-driven, with memory stalled.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            redirect_valid = 1'b1;
            redirect_pc = vt[i].rpc;
            tick();
            redirect_valid = 1'b0;
            @(negedge clk);
            chk("redir_addr", i_addr, vt[i].exp_addr);
            chk("redir_cs_i_n", 32'(cs_i_n), 32'd0);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        i_gnt = 1'b1;
        tick();
        i_gnt = 1'b0;
        @(negedge clk);
        chk("wrap_addr", i_addr, 32'h0);

        // Zero-wait memory, ID always ready: two-cycle startup then one word per cycle.
        do_reset();
        i_gnt = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("zw_c0_cs_i_n", 32'(cs_i_n), 32'd0);
        chk("zw_c0_addr", i_addr, 32'h0);
        chk("zw_c0_valid", 32'(instr_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("zw_c1_valid", 32'(instr_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("zw_c2_valid", 32'(instr_valid), 32'd1);
        chk("zw_c2_pc", pc, 32'h0);
        chk("zw_c2_pc_4", pc_4, 32'h4);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("zw_stream_valid", 32'(instr_valid), 32'd1);
        end

        // ID stalled: credit limits issue to DEPTH requests, then drain resumes fetch at 0x10.
        do_reset();
        i_gnt = 1'b1;
        acc_cnt = 0;
        repeat (8) tick();
        @(negedge clk);
        chk("stall_accepts", 32'(acc_cnt), 32'(DEPTH));
        chk("stall_cs_i_n", 32'(cs_i_n), 32'd1);
        chk("stall_head_pc", pc, 32'h0);
        instr_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("resume_addr", i_addr, 32'h10);
        chk("resume_cs_i_n", 32'(cs_i_n), 32'd0);
        repeat (12) tick();

        // No grant: the request is held steady and nothing is counted as issued.
        do_reset();
        instr_ready = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("nognt_cs_i_n", 32'(cs_i_n), 32'd0);
            chk("nognt_addr", i_addr, 32'h0);
            tick();
        end
        chk("nognt_accepts", 32'(acc_cnt), 32'd0);
        i_gnt = 1'b1;
        repeat (4) tick();

        // Three requests in flight when a redirect to 0x103 arrives.
        do_reset();
        budget = 0;
        i_gnt = 1'b1;
        instr_ready = 1'b1;
        acc_cnt = 0;
        repeat (3) tick();
        i_gnt = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("r3_accepts", 32'(acc_cnt), 32'd3);
        tick();
        redirect_valid = 1'b0;
        i_gnt = 1'b1;
        budget = -1;
        wait_valid(20, "r3_wait");
        chk("r3_pc", pc, 32'h100);
        chk("r3_instr", instr, word(32'h100));
        repeat (4) tick();

        // Redirect in a cycle that also accepts and receives a response.
        do_reset();
        i_gnt = 1'b1;
        instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        chk("rar_rvalid", 32'(i_rvalid), 32'd1);
        chk("rar_accept", 32'(!cs_i_n && i_gnt), 32'd1);
        tick();
        redirect_valid = 1'b0;
        wait_valid(20, "rar_wait");
        chk("rar_pc", pc, 32'h200);
        chk("rar_instr", instr, word(32'h200));
        repeat (4) tick();

        // Random grants, responses, ID stalls and 20 redirects; the scoreboard checks continuity.
        do_reset();
        mem_rand = 1'b1;
        pop_cnt = 0;
        for (int r = 0; r < 20; r++) begin
            gap = $urandom_range(3, 30);
            for (int c = 0; c < gap; c++) begin
                i_gnt = ($urandom_range(0, 3) != 0);
                instr_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            redirect_valid = 1'b1;
            redirect_pc = $urandom & 32'h000F_FFFF;
            tick();
            redirect_valid = 1'b0;
        end
        i_gnt = 1'b1;
        instr_ready = 1'b1;
        repeat (30) tick();
        chk("rand_enough_pops", 32'(pop_cnt >= 20), 32'd1);

        // Reset with two words buffered and two requests still in flight.
        do_reset();
        budget = 0;
        i_gnt = 1'b1;
        acc_cnt = 0;
        repeat (6) tick();
        budget = 2;
        repeat (4) tick();
        @(negedge clk);
        chk("mid_accepts", 32'(acc_cnt), 32'(DEPTH));
        chk("mid_valid", 32'(instr_valid), 32'd1);
        chk("mid_head_pc", pc, 32'h0);
        chk("mid_cs_i_n", 32'(cs_i_n), 32'd1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_cs_i_n", 32'(cs_i_n), 32'd1);
        tick();
        rst = 1'b0;
        budget = -1;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_addr", i_addr, RST_PC);
        chk("post_rst_cs_i_n", 32'(cs_i_n), 32'd0);
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
